core_sequencer: RTL

Multi-cycle control FSM for the single-issue core. It fetches an instruction from the instruction port and holds it in an instruction register that drives the decoder. It generates the decoder's `cycle_counter` input, gates register-file writes, and handshakes with the LSU. It also owns the PC, the retired-instruction counter and the illegal-instruction halt.

---
 rtl/core_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch into IR, sequence EXEC/EXEC2/MEM, own PC, instret and illegal-instruction halt.
// Latency 2 cycles (ALU) or 3 (jump/branch/load/store); fetch and LSU stall for as long as rvalid/done stay low.

package riscv_defines;
    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;
endpackage

module core_sequencer
    import riscv_defines::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,

    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                        instr_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,

    output logic [RISCV_WORD_WIDTH-1:0] instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] pc_o,
    output logic                        cycle_counter_o,

    input  logic                        jump_inst_i,
    input  logic                        branch_inst_i,
    input  logic                        illegal_inst_i,
    input  logic                        compressed_inst_i,
    input  logic                        lsu_r_en_i,
    input  logic                        lsu_w_en_i,

    input  logic [RISCV_WORD_WIDTH-1:0] alu_result_i,

    output logic                        lsu_req_o,
    input  logic                        lsu_done_i,

    output logic                        rf_we_gate_o,
    output logic [31:0]                 instret_o,
    output logic                        halted_o
);

    localparam logic [RISCV_WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        EXEC2 = 3'd3,
        MEM   = 3'd4,
        TRAP  = 3'd5
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [RISCV_ADDR_WIDTH-1:0]   pc;
    logic [RISCV_ADDR_WIDTH-1:0]   pc_next;
    logic [RISCV_WORD_WIDTH-1:0]   instr;
    logic [RISCV_WORD_WIDTH-1:0]   instr_next;
    logic [31:0]                   instret;
    logic [31:0]                   instret_next;
    logic                          taken;
    logic                          taken_next;

    logic [RISCV_ADDR_WIDTH-1:0]   inc;
    logic [RISCV_ADDR_WIDTH-1:0]   pc_seq;
    logic [RISCV_ADDR_WIDTH-1:0]   pc_target;
    logic                          mem_access;

    assign inc        = compressed_inst_i ? RISCV_ADDR_WIDTH'(2) : RISCV_ADDR_WIDTH'(4);
    assign pc_seq     = pc + inc;
    // Targets may be halfword aligned; only bit 0 is forced clear.
    assign pc_target  = {alu_result_i[RISCV_ADDR_WIDTH-1:1], 1'b0};
    assign mem_access = lsu_r_en_i | lsu_w_en_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= BOOT_ADDR;
            instr   <= NOP_INSTR;
            instret <= 32'd0;
            taken   <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            instr   <= instr_next;
            instret <= instret_next;
            taken   <= taken_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_next      = instr;
        instret_next    = instret;
        taken_next      = taken;
        instr_req_o     = 1'b0;
        lsu_req_o       = 1'b0;
        rf_we_gate_o    = 1'b0;
        cycle_counter_o = 1'b0;
        halted_o        = 1'b0;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                instr_req_o = 1'b1;
                if (instr_rvalid_i) begin
                    instr_next = instr_rdata_i;
                    state_next = EXEC;
                end
            end

            EXEC: begin
                if (illegal_inst_i) begin
                    state_next = TRAP;
                end else if (mem_access) begin
                    lsu_req_o  = 1'b1;
                    state_next = MEM;
                end else if (jump_inst_i) begin
                    // Link value (PC+2/4) comes out of the ALU this cycle.
                    rf_we_gate_o = 1'b1;
                    state_next   = EXEC2;
                end else if (branch_inst_i) begin
                    taken_next = alu_result_i[0];
                    state_next = EXEC2;
                end else begin
                    rf_we_gate_o = 1'b1;
                    pc_next      = pc_seq;
                    instret_next = instret + 32'd1;
                    state_next   = FETCH;
                end
            end

            EXEC2: begin
                cycle_counter_o = 1'b1;
                if (jump_inst_i || taken) begin
                    pc_next = pc_target;
                end else begin
                    pc_next = pc_seq;
                end
                instret_next = instret + 32'd1;
                state_next   = FETCH;
            end

            MEM: begin
                lsu_req_o = 1'b1;
                if (lsu_done_i) begin
                    // Stores also open the gate; their decoder rf_we is low.
                    rf_we_gate_o = 1'b1;
                    pc_next      = pc_seq;
                    instret_next = instret + 32'd1;
                    state_next   = FETCH;
                end
            end

            TRAP: begin
                halted_o = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign instr_addr_o = pc;
    assign pc_o         = pc;
    assign instr_o      = instr;
    assign instret_o    = instret;

endmodule
